exfifo_pkt_ctrl: RTL

Packet sequencer for the external host FIFO pair (`exfifo_if_*` / `exfifo_of_*`) feeding the LMS control CPU subsystem. It reads one fixed-length command packet from the input FIFO into an internal buffer and hands it to the consumer (CPU-side logic) through a valid/done handshake. The consumer writes the response into the same buffer, and the block then streams it to the output FIFO. It also owns the FIFO reset line, both at power-up and on software request.

---
 rtl/exfifo_pkt_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/exfifo_pkt_ctrl.sv
// Packet sequencer between the host FIFO pair and the control CPU: captures one command
// packet, hands it to the consumer, then streams the in-place response back out.
module exfifo_pkt_ctrl #(
    parameter int unsigned PKT_WORDS  = 16,
    parameter int unsigned RST_CYCLES = 8,
    localparam int unsigned AW = $clog2(PKT_WORDS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   if_d,
    output logic          if_rd,
    input  logic          if_rdempty,
    output logic [31:0]   of_d,
    output logic          of_wr,
    input  logic          of_wrfull,
    output logic          fifo_rst,
    input  logic          sw_rst,
    output logic          cmd_valid,
    input  logic [AW-1:0] cmd_addr,
    output logic [31:0]   cmd_rdata,
    input  logic          rsp_we,
    input  logic [AW-1:0] rsp_addr,
    input  logic [31:0]   rsp_wdata,
    input  logic          cmd_done,
    output logic [15:0]   pkt_cnt
);

    localparam logic [AW:0]   WordsC   = PKT_WORDS[AW:0];
    localparam logic [AW:0]   LastWC   = WordsC - 1'b1;
    localparam logic [31:0]   RstLastC = RST_CYCLES - 1;

    typedef enum logic [2:0] {StRst, StIdle, StRx, StCmd, StTx} state_e;

    state_e      state_q;
    logic [31:0] rst_cnt_q;
    logic [AW:0] rd_cnt_q;
    logic [AW:0] cap_cnt_q;
    logic [AW:0] tx_cnt_q;
    logic        rd_q;
    logic [15:0] pkt_cnt_q;
    logic [31:0] pkt_buf_q [PKT_WORDS];

    assign if_rd     = (state_q == StRx) && !if_rdempty && (rd_cnt_q < WordsC);
    assign of_wr     = (state_q == StTx) && !of_wrfull;
    assign of_d      = (state_q == StTx) ? pkt_buf_q[tx_cnt_q[AW-1:0]] : '0;
    assign cmd_valid = (state_q == StCmd);
    assign fifo_rst  = (state_q == StRst);
    assign cmd_rdata = pkt_buf_q[cmd_addr];
    assign pkt_cnt   = pkt_cnt_q;

    // Packet storage is not reset so a software FIFO reset leaves it intact.
    always_ff @(posedge clk) begin
        if (!sw_rst) begin
            if (state_q == StRx && rd_q) begin
                pkt_buf_q[cap_cnt_q[AW-1:0]] <= if_d;
            end else if (state_q == StCmd && rsp_we) begin
                pkt_buf_q[rsp_addr] <= rsp_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StRst;
            rst_cnt_q <= '0;
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            tx_cnt_q  <= '0;
            rd_q      <= 1'b0;
            pkt_cnt_q <= '0;
        end else if (sw_rst) begin
            state_q   <= StRst;
            rst_cnt_q <= '0;
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            tx_cnt_q  <= '0;
            rd_q      <= 1'b0;
        end else begin
            case (state_q)
                StRst: begin
                    if (rst_cnt_q == RstLastC) begin
                        state_q <= StIdle;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    rd_cnt_q  <= '0;
                    cap_cnt_q <= '0;
                    rd_q      <= 1'b0;
                    if (!if_rdempty) begin
                        state_q <= StRx;
                    end
                end
                StRx: begin
                    // Non-showahead FIFO: data for a read arrives one cycle later.
                    rd_q <= if_rd;
                    if (if_rd) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                    if (rd_q) begin
                        cap_cnt_q <= cap_cnt_q + 1'b1;
                        if (cap_cnt_q == LastWC) begin
                            state_q <= StCmd;
                        end
                    end
                end
                StCmd: begin
                    if (cmd_done) begin
                        state_q  <= StTx;
                        tx_cnt_q <= '0;
                    end
                end
                StTx: begin
                    if (of_wr) begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                        if (tx_cnt_q == LastWC) begin
                            state_q   <= StIdle;
                            pkt_cnt_q <= pkt_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= StRst;
                    rst_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule
